algo_4wt_wr_ingress_buf: RTL
============================

// Module: algo_4wt_wr_ingress_buf
// PURPOSE
//  Write-ingress buffer sitting directly upstream of the 1r4wt memory top.
//  It accepts client writes on 4 independent valid/ready ports and holds each in a per-port FIFO.
//  It drains the FIFOs onto the top's write/wr_adr/din bus, honouring the per-port wr_bp backpressure and the top's ready.
//  Writes are never dropped; per-port order is preserved. There is no ordering between ports.
// PARAMETERS
//  WIDTH    32   data width per port
//  BITADDR  13   address width per port
//  NUMWRPT  4    number of write ports; fixed at 4
//  DEPTH    4    entries per port FIFO; must be a power of 2, >=2
//  BITDPTH  2    log2(DEPTH)
// PORTS
//  clk      in   1                   clock
//  rst      in   1                   async reset, active-low; asserts asynchronously, deasserts synchronously to clk
//  in_vld   in   NUMWRPT             client write request, per port
//  in_adr   in   NUMWRPT*BITADDR     client address; port p occupies bits [p*BITADDR +: BITADDR]
//  in_din   in   NUMWRPT*WIDTH       client data; port p occupies bits [p*WIDTH +: WIDTH]
//  in_rdy   out  NUMWRPT             FIFO can accept, per port
//  mem_rdy  in   1                   ready from the memory top (initialisation done)
//  wr_bp    in   NUMWRPT             backpressure from the memory top, per port
//  write    out  NUMWRPT             write strobe to the memory top
//  wr_adr   out  NUMWRPT*BITADDR     write address to the memory top
//  din      out  NUMWRPT*WIDTH       write data to the memory top
//  occ      out  NUMWRPT*(BITDPTH+1) per-port FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=0) values:
//    - in_rdy=0, write=0, wr_adr=0, din=0, occ=0.
//    - All read/write pointers and counts are cleared.
//  - Reset mid-operation flushes all FIFOs; queued writes are discarded.
//  - in_rdy[p] = rst_sync_done & (cnt[p] != DEPTH).
//    - Decoded from registered state only; it does not depend on a pop in the same cycle.
//    - in_rdy stays 0 for the first cycle after reset deassert.
//  - Push: in_vld[p] & in_rdy[p] at edge N writes {adr,din} at wptr[p].
//    - wptr advances and wraps modulo DEPTH.
//    - in_vld while in_rdy=0 is ignored; the client must hold the request.
//  - Pop condition at edge N: mem_rdy & ~wr_bp[p] & (cnt[p]!=0).
//    - Read the head at rptr[p] and advance rptr.
//    - write[p], wr_adr[p] and din[p] are registered with the head during cycle N+1; write[p]=0 otherwise.
//    - wr_adr/din hold their last values when write=0.
//  - Empty-FIFO latency: accepted at edge N -> write[p]=1 during cycle N+2. There is no bypass path.
//  - Push and pop on the same edge: cnt unchanged. Push only: cnt+1. Pop only: cnt-1.
//    - cnt is BITDPTH+1 bits and never exceeds DEPTH.
//  - occ[p] = cnt[p], registered.
//  - mem_rdy=0 stalls all pops. Pushes continue until the FIFOs are full.
//  - wr_bp[p] stalls only port p. Throughput is 1 write/cycle/port with no backpressure.
// CONFIGURATION
//  - ALGO_WRBUF_HWM_EN defined:
//    - Adds output hwm [NUMWRPT*(BITDPTH+1)], the per-port high-water mark of cnt.
//    - Adds input hwm_clr [1]; when it is 1, all hwm values load the current cnt.
//    - Reset value of hwm is 0.
//  - ALGO_WRBUF_HWM_EN undefined: hwm/hwm_clr ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset sequence:
//     - Stimulus: rst=0 for 3 cycles, then release.
//     - Response: all outputs 0; in_rdy=4'hF from the 2nd cycle after release; occ=0.
//  2. Single write, empty FIFO:
//     - Stimulus: port2 adr=13'h0A5, din=32'hDEADBEEF accepted at edge N; mem_rdy=1, wr_bp=0.
//     - Response: write=4'b0100 for exactly 1 cycle, in cycle N+2, with the same adr/din.
//  3. Fill under backpressure (DEPTH=4):
//     - Stimulus: wr_bp[0]=1; push 5 writes to port0 with din=1..5.
//     - Response: after 4 accepts, in_rdy[0]=0 and occ0=4; the 5th is held by the client.
//     - Stimulus: release wr_bp[0].
//     - Response: write[0] outputs din 1,2,3,4,5 on consecutive cycles.
//  4. Simultaneous push/pop at full:
//     - Stimulus: occ0=4; drop wr_bp, then push on the cycle in_rdy rises.
//     - Response: occ stays at 3 while continuous push/pop runs; order is preserved; pointer wrap is verified over 10 writes.
//  5. mem_rdy=0 with 4 ports active:
//     - Response: no write strobes; all occ reach 4.
//     - Stimulus: raise mem_rdy.
//     - Response: write=4'hF for 4 consecutive cycles.
//  6. Reset mid-drain:
//     - Stimulus: occ=3 on port1; pulse rst=0.
//     - Response: write=0 immediately (asynchronous); occ=0; no stale write appears after release.

Source files
------------

// File: rtl/algo_4wt_wr_ingress_buf_if.sv
// ---------------------------------------------------------------------------
// algo_4wt_wr_ingress_buf_if
//   Bundles the client write-request side and the memory-top write side of
//   the 4-port write-ingress buffer.
//
//   Client side : in_vld, in_adr, in_din (to buffer), in_rdy (from buffer)
//   Memory side : mem_rdy, wr_bp (to buffer), write, wr_adr, din (from buffer)
//   Port p occupies bits [p*BITADDR +: BITADDR] of the address buses and
//   bits [p*WIDTH +: WIDTH] of the data buses.
//
//   modport slave  : the buffer itself
//   modport master : whatever drives clients and models the memory top
// ---------------------------------------------------------------------------
interface algo_4wt_wr_ingress_buf_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int NUMWRPT = 4
);
  logic [NUMWRPT-1:0]         in_vld;
  logic [NUMWRPT*BITADDR-1:0] in_adr;
  logic [NUMWRPT*WIDTH-1:0]   in_din;
  logic [NUMWRPT-1:0]         in_rdy;
  logic                       mem_rdy;
  logic [NUMWRPT-1:0]         wr_bp;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;

  modport slave (
    input  in_vld, in_adr, in_din, mem_rdy, wr_bp,
    output in_rdy, write, wr_adr, din
  );

  modport master (
    output in_vld, in_adr, in_din, mem_rdy, wr_bp,
    input  in_rdy, write, wr_adr, din
  );
endinterface

// File: rtl/algo_4wt_wr_ingress_buf.sv
// ---------------------------------------------------------------------------
// algo_4wt_wr_ingress_buf
//   Write-ingress buffer in front of the 1r4wt memory top. Each of the 4
//   write ports has its own DEPTH-entry FIFO. Client writes are accepted on
//   a valid/ready handshake and drained onto the memory write bus whenever
//   the memory top is ready and that port is not backpressured. Writes are
//   never dropped and per-port order is preserved; ports are independent.
//
// Ports
//   clk      : clock
//   rst      : asynchronous active-low reset, released synchronously to clk
//   bus      : algo_4wt_wr_ingress_buf_if.slave (client + memory-top buses)
//   occ      : per-port FIFO occupancy, (BITDPTH+1) bits per port, registered
//   hwm_clr  : (ALGO_WRBUF_HWM_EN only) load every high-water mark with cnt
//   hwm      : (ALGO_WRBUF_HWM_EN only) per-port high-water mark of cnt
//
// Optional feature macro: ALGO_WRBUF_HWM_EN
//
// Timing: a write accepted at edge N into an empty FIFO is popped at edge
// N+1 and appears on write/wr_adr/din after that edge (no bypass path).
// ---------------------------------------------------------------------------
module algo_4wt_wr_ingress_buf #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int NUMWRPT = 4,
  parameter int DEPTH   = 4,
  parameter int BITDPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  algo_4wt_wr_ingress_buf_if.slave         bus,
  output logic [NUMWRPT*(BITDPTH+1)-1:0]   occ
`ifdef ALGO_WRBUF_HWM_EN
  ,
  input  logic                             hwm_clr,
  output logic [NUMWRPT*(BITDPTH+1)-1:0]   hwm
`endif
);

  typedef logic [BITDPTH-1:0] ptr_t;
  typedef logic [BITDPTH:0]   cnt_t;

  typedef struct packed {
    logic [BITADDR-1:0] adr;
    logic [WIDTH-1:0]   dat;
  } entry_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // Registered state
  logic                    rst_sync_done_q, rst_sync_done_d;
  ptr_t                    wptr_q   [NUMWRPT];
  ptr_t                    wptr_d   [NUMWRPT];
  ptr_t                    rptr_q   [NUMWRPT];
  ptr_t                    rptr_d   [NUMWRPT];
  cnt_t                    cnt_q    [NUMWRPT];
  cnt_t                    cnt_d    [NUMWRPT];
  logic [NUMWRPT-1:0]      write_q, write_d;
  logic [BITADDR-1:0]      wr_adr_q [NUMWRPT];
  logic [BITADDR-1:0]      wr_adr_d [NUMWRPT];
  logic [WIDTH-1:0]        din_q    [NUMWRPT];
  logic [WIDTH-1:0]        din_d    [NUMWRPT];
  entry_t                  mem_q    [NUMWRPT][DEPTH];

  // Per-cycle decode
  logic [NUMWRPT-1:0]      in_rdy_w;
  logic [NUMWRPT-1:0]      push;
  logic [NUMWRPT-1:0]      pop;
  entry_t                  push_ent [NUMWRPT];
  entry_t                  head_ent [NUMWRPT];

  // NOTE: every signal assigned in always_comb gets a default before any
  // conditional update, so no path can leave it unassigned (no latch).
  always_comb begin
    rst_sync_done_d = 1'b1;
    for (int p = 0; p < NUMWRPT; p++) begin
      // Ready comes from registered state only, so it never depends on a
      // pop in the same cycle; a full FIFO reopens one cycle after a pop.
      in_rdy_w[p]    = rst_sync_done_q & (cnt_q[p] != CNT_FULL);
      push[p]        = bus.in_vld[p] & in_rdy_w[p];
      pop[p]         = bus.mem_rdy & ~bus.wr_bp[p] & (cnt_q[p] != '0);
      push_ent[p]    = '{adr: bus.in_adr[p*BITADDR +: BITADDR],
                         dat: bus.in_din[p*WIDTH +: WIDTH]};
      head_ent[p]    = mem_q[p][rptr_q[p]];

      // Pointers wrap naturally because DEPTH is a power of 2.
      wptr_d[p]      = push[p] ? wptr_q[p] + ptr_t'(1) : wptr_q[p];
      rptr_d[p]      = pop[p]  ? rptr_q[p] + ptr_t'(1) : rptr_q[p];

      cnt_d[p]       = cnt_q[p];
      unique case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + cnt_t'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - cnt_t'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase

      // Address/data hold their last value when no write is issued.
      write_d[p]     = pop[p];
      wr_adr_d[p]    = pop[p] ? head_ent[p].adr : wr_adr_q[p];
      din_d[p]       = pop[p] ? head_ent[p].dat : din_q[p];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_done_q <= 1'b0;
      write_q         <= '0;
      for (int p = 0; p < NUMWRPT; p++) begin
        wptr_q[p]   <= '0;
        rptr_q[p]   <= '0;
        cnt_q[p]    <= '0;
        wr_adr_q[p] <= '0;
        din_q[p]    <= '0;
      end
    end else begin
      rst_sync_done_q <= rst_sync_done_d;
      write_q         <= write_d;
      for (int p = 0; p < NUMWRPT; p++) begin
        wptr_q[p]   <= wptr_d[p];
        rptr_q[p]   <= rptr_d[p];
        cnt_q[p]    <= cnt_d[p];
        wr_adr_q[p] <= wr_adr_d[p];
        din_q[p]    <= din_d[p];
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; cnt/pointers being cleared
  // guarantees no entry is read before it has been written.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUMWRPT; p++) begin
      if (push[p]) begin
        mem_q[p][wptr_q[p]] <= push_ent[p];
      end
    end
  end

  // Flatten per-port registers onto the packed buses.
  always_comb begin
    bus.in_rdy = in_rdy_w;
    bus.write  = write_q;
    bus.wr_adr = '0;
    bus.din    = '0;
    occ        = '0;
    for (int p = 0; p < NUMWRPT; p++) begin
      bus.wr_adr[p*BITADDR +: BITADDR]   = wr_adr_q[p];
      bus.din[p*WIDTH +: WIDTH]          = din_q[p];
      occ[p*(BITDPTH+1) +: (BITDPTH+1)]  = cnt_q[p];
    end
  end

`ifdef ALGO_WRBUF_HWM_EN
  cnt_t hwm_q [NUMWRPT];
  cnt_t hwm_d [NUMWRPT];

  always_comb begin
    hwm = '0;
    for (int p = 0; p < NUMWRPT; p++) begin
      if (hwm_clr) begin
        hwm_d[p] = cnt_q[p];
      end else if (cnt_q[p] > hwm_q[p]) begin
        hwm_d[p] = cnt_q[p];
      end else begin
        hwm_d[p] = hwm_q[p];
      end
      hwm[p*(BITDPTH+1) +: (BITDPTH+1)] = hwm_q[p];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUMWRPT; p++) hwm_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUMWRPT; p++) hwm_q[p] <= hwm_d[p];
    end
  end
`endif

endmodule
